// File: rtl/invaders_load_ctrl.sv
// Download steering for the Invaders core.
// Owns the game-ROM write port while the HPS streams a download, routes
// machine-select and DIP bytes into configuration registers, and keeps the
// CPU/video core in reset while loading and for a fixed time afterwards.
module invaders_load_ctrl #(
  parameter int ROM_AW    = 13,
  parameter int WR_CYCLES = 2,
  parameter int RST_HOLD  = 16,
  parameter int ROM_INDEX = 0,
  parameter int MOD_INDEX = 1,
  parameter int DIP_INDEX = 254
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic [ROM_AW-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              cpu_rst,
  output logic [7:0]        mod,
  output logic [7:0]        sw0,
  output logic [7:0]        sw1,
  output logic [7:0]        sw2,
  output logic [ROM_AW:0]   rom_len,
  output logic              err_drop
);

  localparam int BW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [BW-1:0] BUSY_LOAD = BW'(WR_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [7:0]    ROM_IDX   = 8'(ROM_INDEX);
  localparam logic [7:0]    MOD_IDX   = 8'(MOD_INDEX);
  localparam logic [7:0]    DIP_IDX   = 8'(DIP_INDEX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_next;
  logic [BW-1:0]   busy_cnt;
  logic [BW-1:0]   busy_next;
  logic            dl_prev;
  logic            rom_strobe;
  logic            in_range;
  logic            accept;
  logic            len_clear;
  logic [ROM_AW:0] addr_len;
  logic [ROM_AW:0] len_base;
  logic [ROM_AW:0] len_next;

  // ROM strobe qualification: the single-entry buffer must be empty and the
  // address must fit inside the ROM window, otherwise the byte is lost.
  always_comb begin
    rom_strobe = ioctl_wr && (ioctl_index == ROM_IDX);
    in_range   = ((ioctl_addr >> ROM_AW) == 25'd0);
    accept     = rom_strobe && (busy_cnt == {BW{1'b0}}) && in_range;
    len_clear  = ioctl_download && !dl_prev && (ioctl_index == ROM_IDX);
    addr_len   = {1'b0, ioctl_addr[ROM_AW-1:0]} + (ROM_AW + 1)'(1);
    if (len_clear) begin
      len_base = {(ROM_AW + 1){1'b0}};
    end else begin
      len_base = rom_len;
    end
    if (accept && (addr_len > len_base)) begin
      len_next = addr_len;
    end else begin
      len_next = len_base;
    end
  end

  // Write-buffer occupancy: reload on accept, otherwise count down to empty.
  always_comb begin
    busy_next = busy_cnt;
    if (accept) begin
      busy_next = BUSY_LOAD;
    end else if (busy_cnt != {BW{1'b0}}) begin
      busy_next = busy_cnt - BW'(1);
    end else begin
      busy_next = {BW{1'b0}};
    end
  end

  // ROM write port, back-pressure, length tracking and sticky drop flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      busy_cnt   <= {BW{1'b0}};
      ioctl_wait <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {ROM_AW{1'b0}};
      mem_data   <= 8'h00;
      rom_len    <= {(ROM_AW + 1){1'b0}};
      err_drop   <= 1'b0;
      dl_prev    <= 1'b0;
    end else begin
      busy_cnt   <= busy_next;
      ioctl_wait <= (busy_next != {BW{1'b0}});
      mem_we     <= accept;
      rom_len    <= len_next;
      dl_prev    <= ioctl_download;
      if (accept) begin
        mem_addr <= ioctl_addr[ROM_AW-1:0];
        mem_data <= ioctl_dout;
      end else begin
        mem_addr <= mem_addr;
        mem_data <= mem_data;
      end
      if (rom_strobe && !accept) begin
        err_drop <= 1'b1;
      end else begin
        err_drop <= err_drop;
      end
    end
  end

  // Configuration bytes: machine select and the three DIP banks.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mod <= 8'h00;
      sw0 <= 8'h00;
      sw1 <= 8'h00;
      sw2 <= 8'h00;
    end else begin
      if (ioctl_wr && (ioctl_index == MOD_IDX)) begin
        mod <= ioctl_dout;
      end else begin
        mod <= mod;
      end
      if (ioctl_wr && (ioctl_index == DIP_IDX) && (ioctl_addr[24:2] == 23'd0)) begin
        case (ioctl_addr[1:0])
          2'd0:    sw0 <= ioctl_dout;
          2'd1:    sw1 <= ioctl_dout;
          2'd2:    sw2 <= ioctl_dout;
          default: sw0 <= sw0;
        endcase
      end else begin
        sw0 <= sw0;
      end
    end
  end

  // Core-reset sequencer next-state logic; download always wins back to LOAD.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      IDLE: begin
        if (ioctl_download) begin
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
        hold_next = {HW{1'b0}};
      end
      LOAD: begin
        if (!ioctl_download) begin
          state_next = DRAIN;
        end else begin
          state_next = LOAD;
        end
        hold_next = {HW{1'b0}};
      end
      DRAIN: begin
        if (ioctl_download) begin
          state_next = LOAD;
        end else if (busy_cnt == {BW{1'b0}}) begin
          state_next = HOLD;
        end else begin
          state_next = DRAIN;
        end
        hold_next = {HW{1'b0}};
      end
      HOLD: begin
        if (ioctl_download) begin
          state_next = LOAD;
          hold_next  = {HW{1'b0}};
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = IDLE;
          hold_next  = {HW{1'b0}};
        end else begin
          state_next = HOLD;
          hold_next  = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_next = HOLD;
        hold_next  = {HW{1'b0}};
      end
    endcase
  end

  // Sequencer state register; cpu_rst follows the next state so it drops on
  // the same edge the sequencer enters IDLE.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= HOLD;
      hold_cnt <= {HW{1'b0}};
      cpu_rst  <= 1'b1;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      cpu_rst  <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_invaders_load_ctrl.sv
// Directed self-checking bench for invaders_load_ctrl with default parameters.
module tb_invaders_load_ctrl;

  logic        clk_sys;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        cpu_rst;
  logic [7:0]  mod;
  logic [7:0]  sw0;
  logic [7:0]  sw1;
  logic [7:0]  sw2;
  logic [13:0] rom_len;
  logic        err_drop;

  int checks   = 0;
  int failures = 0;
  int n;

  invaders_load_ctrl dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .cpu_rst        (cpu_rst),
    .mod            (mod),
    .sw0            (sw0),
    .sw1            (sw1),
    .sw2            (sw2),
    .rom_len        (rom_len),
    .err_drop       (err_drop)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'h00;
    ioctl_index    = 8'd0;
    tick();
    tick();

    // Reset state
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mod", 32'(mod), 32'd0);
    check("rst_sw", {8'd0, sw0, sw1, sw2}, 32'd0);
    check("rst_rom_len", 32'(rom_len), 32'd0);
    check("rst_err", 32'(err_drop), 32'd0);

    // Test 1: reset released, no download -> 16 cycles of cpu_rst
    reset = 1'b0;
    n = 0;
    while (cpu_rst && n < 40) begin
      tick();
      n++;
    end
    check("t1_hold_cycles", 32'(n), 32'd16);
    check("t1_cpu_rst_low", 32'(cpu_rst), 32'd0);

    // Test 2: ROM download, addr 0..3 spaced two cycles
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    check("t2_cpu_rst", 32'(cpu_rst), 32'd1);
    for (int a = 0; a < 4; a++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'h10 + 8'(a);
      tick();
      ioctl_wr = 1'b0;
      check("t2_we", 32'(mem_we), 32'd1);
      check("t2_addr", 32'(mem_addr), 32'(a));
      check("t2_data", 32'(mem_data), 32'h10 + 32'(a));
      check("t2_wait_hi", 32'(ioctl_wait), 32'd1);
      tick();
      check("t2_we_lo", 32'(mem_we), 32'd0);
      check("t2_wait_lo", 32'(ioctl_wait), 32'd0);
    end
    check("t2_rom_len", 32'(rom_len), 32'd4);
    check("t2_err", 32'(err_drop), 32'd0);

    // Test 4: out-of-range address 0x2000 is dropped
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h2000;
    ioctl_dout = 8'hEE;
    tick();
    ioctl_wr = 1'b0;
    check("t4_we", 32'(mem_we), 32'd0);
    check("t4_err", 32'(err_drop), 32'd1);
    check("t4_rom_len", 32'(rom_len), 32'd4);
    check("t4_addr_held", 32'(mem_addr), 32'd3);

    // Reset coincident with an acceptable strobe: no write follows
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'd7;
    ioctl_dout     = 8'h77;
    ioctl_download = 1'b0;
    reset          = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    reset    = 1'b0;
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_err", 32'(err_drop), 32'd0);
    check("rst_mid_len", 32'(rom_len), 32'd0);
    check("rst_mid_cpu", 32'(cpu_rst), 32'd1);
    tick();
    check("rst_mid_we2", 32'(mem_we), 32'd0);

    // Test 3: back-to-back strobes, second one dropped
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd5;
    ioctl_dout = 8'h55;
    tick();
    check("t3_we1", 32'(mem_we), 32'd1);
    check("t3_wait", 32'(ioctl_wait), 32'd1);
    ioctl_addr = 25'd6;
    ioctl_dout = 8'h66;
    tick();
    ioctl_wr = 1'b0;
    check("t3_we2", 32'(mem_we), 32'd0);
    check("t3_err", 32'(err_drop), 32'd1);
    check("t3_addr", 32'(mem_addr), 32'd5);
    check("t3_data", 32'(mem_data), 32'h55);
    check("t3_rom_len", 32'(rom_len), 32'd6);
    tick();
    check("t3_we3", 32'(mem_we), 32'd0);

    // Test 5: machine byte, DIP bytes, ignored index and address
    ioctl_wr    = 1'b1;
    ioctl_index = 8'd1;
    ioctl_addr  = 25'd9;
    ioctl_dout  = 8'h06;
    tick();
    check("t5_mod", 32'(mod), 32'h06);
    ioctl_index = 8'd254;
    ioctl_addr = 25'd0; ioctl_dout = 8'hAA; tick();
    ioctl_addr = 25'd1; ioctl_dout = 8'hBB; tick();
    ioctl_addr = 25'd2; ioctl_dout = 8'hCC; tick();
    ioctl_addr = 25'd3; ioctl_dout = 8'hDD; tick();
    ioctl_addr = 25'd4; ioctl_dout = 8'h44; tick();
    check("t5_sw0", 32'(sw0), 32'hAA);
    check("t5_sw1", 32'(sw1), 32'hBB);
    check("t5_sw2", 32'(sw2), 32'hCC);
    check("t5_dip_we", 32'(mem_we), 32'd0);
    ioctl_index = 8'd7;
    ioctl_addr  = 25'd0;
    ioctl_dout  = 8'h99;
    tick();
    ioctl_wr = 1'b0;
    check("t5_other_mod", 32'(mod), 32'h06);
    check("t5_other_sw0", 32'(sw0), 32'hAA);
    check("t5_other_we", 32'(mem_we), 32'd0);
    check("t5_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t5_rom_len", 32'(rom_len), 32'd6);

    // Test 6: download falls, returns after 5 HOLD cycles, falls again
    ioctl_index    = 8'd254;
    ioctl_download = 1'b0;
    tick();
    check("t6_drain_rst", 32'(cpu_rst), 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_hold_rst", 32'(cpu_rst), 32'd1);
    end
    ioctl_download = 1'b1;
    tick();
    check("t6_reload_rst", 32'(cpu_rst), 32'd1);
    check("t6_len_kept", 32'(rom_len), 32'd6);
    ioctl_download = 1'b0;
    n = 0;
    while (cpu_rst && n < 60) begin
      tick();
      n++;
    end
    check("t6_release", 32'(n), 32'd18);
    check("t6_cpu_rst_low", 32'(cpu_rst), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
